// File: rtl/zif_rx_framer.sv
// ZIF sample stream to AXI-stream framer with FWFT FIFO, overflow and frame counters.
// Optional macro ZIF_FRAMER_HDR_EN inserts a {16'hA5A5, seq} header word before each frame.
module zif_rx_framer #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                        axis_clk,
    input  logic                        rst_n,
    input  logic                        enable_in,
    input  logic [LEN_W-1:0]            frame_len_in,
    input  logic                        clr_cnt_in,
    input  logic                        sample_valid_in,
    input  logic [31:0]                 sample_data_in,
    output logic                        axis_tx_tvalid,
    input  logic                        axis_tx_tready,
    output logic [31:0]                 axis_tx_tdata,
    output logic                        axis_tx_tlast,
    output logic [3:0]                  axis_tx_tkeep,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
    output logic [LEN_W-1:0]            ovf_cnt_out,
    output logic [LEN_W-1:0]            frame_cnt_out
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [0:0]  WR_IDLE   = 1'b0;
    localparam logic [0:0]  WR_ACTIVE = 1'b1;

    logic [32:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [AW:0]      w_level_d;
    logic [0:0]       r_wr_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_ovf;
    logic [LEN_W-1:0] r_frames;

    logic             w_full;
    logic             w_empty;
    logic [32:0]      w_head;
    logic             w_pop;
    logic             w_idle;
    logic             w_want;
    logic             w_wr_en;
    logic             w_wr_last;
    logic             w_ovf_evt;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_cur_len;
    logic [LEN_W-1:0] w_idx;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rptr];
    assign w_idle  = (r_wr_state == WR_IDLE);

    // A sample belongs to a frame if one is open, or if enable allows a new one to start.
    assign w_want    = sample_valid_in && (!w_idle || enable_in);
    assign w_wr_en   = w_want && (!w_full || w_pop);
    assign w_ovf_evt = w_want && !w_wr_en;
    assign w_len_eff = (frame_len_in == '0) ? LEN_W'(1) : frame_len_in;
    assign w_cur_len = w_idle ? w_len_eff : r_len;
    assign w_idx     = w_idle ? LEN_W'(1) : r_cnt + LEN_W'(1);
    assign w_wr_last = (w_idx == w_cur_len);

    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= WR_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
        end else if (w_wr_en) begin
            r_wr_state <= w_wr_last ? WR_IDLE : WR_ACTIVE;
            r_cnt      <= w_idx;
            if (w_idle) begin
                r_len <= w_len_eff;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= {w_wr_last, sample_data_in};
        end
    end

    always_comb begin
        w_level_d = r_level;
        case ({w_wr_en, w_pop})
            2'b10:   w_level_d = r_level + (AW+1)'(1);
            2'b01:   w_level_d = r_level - (AW+1)'(1);
            default: w_level_d = r_level;
        endcase
    end

    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_d;
        end
    end

    // Clear has priority over any count event in the same cycle.
    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf    <= '0;
            r_frames <= '0;
        end else if (clr_cnt_in) begin
            r_ovf    <= '0;
            r_frames <= '0;
        end else begin
            if (w_wr_en && w_wr_last) begin
                r_frames <= r_frames + LEN_W'(1);
            end
            if (w_ovf_evt && (r_ovf != '1)) begin
                r_ovf <= r_ovf + LEN_W'(1);
            end
        end
    end

`ifdef ZIF_FRAMER_HDR_EN
    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_HDR  = 2'd1;
    localparam logic [1:0] OUT_DATA = 2'd2;

    logic [1:0]  r_out_state;
    logic [15:0] r_seq;

    always_comb begin
        w_pop          = 1'b0;
        axis_tx_tvalid = 1'b0;
        axis_tx_tdata  = '0;
        axis_tx_tlast  = 1'b0;
        case (r_out_state)
            OUT_HDR: begin
                axis_tx_tvalid = 1'b1;
                axis_tx_tdata  = {16'hA5A5, r_seq};
            end
            OUT_DATA: begin
                axis_tx_tvalid = !w_empty;
                axis_tx_tdata  = w_empty ? 32'h0 : w_head[31:0];
                axis_tx_tlast  = !w_empty && w_head[32];
                w_pop          = !w_empty && axis_tx_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_state <= OUT_IDLE;
            r_seq       <= '0;
        end else begin
            case (r_out_state)
                OUT_IDLE: if (!w_empty) r_out_state <= OUT_HDR;
                OUT_HDR: begin
                    if (axis_tx_tready) begin
                        r_out_state <= OUT_DATA;
                        r_seq       <= r_seq + 16'd1;
                    end
                end
                OUT_DATA: if (w_pop && w_head[32]) r_out_state <= OUT_IDLE;
                default:  r_out_state <= OUT_IDLE;
            endcase
        end
    end
`else
    always_comb begin
        axis_tx_tvalid = !w_empty;
        axis_tx_tdata  = w_empty ? 32'h0 : w_head[31:0];
        axis_tx_tlast  = !w_empty && w_head[32];
        w_pop          = !w_empty && axis_tx_tready;
    end
`endif

    assign axis_tx_tkeep  = 4'hF;
    assign fifo_level_out = r_level;
    assign ovf_cnt_out    = r_ovf;
    assign frame_cnt_out  = r_frames;

endmodule

// File: tb/tb_zif_rx_framer.sv
// Randomized bench for zif_rx_framer against a queue-based model of the framed output stream.
// Follows ZIF_FRAMER_HDR_EN if defined at compile time.
module tb_zif_rx_framer;

    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_in = 1'b0;
    logic [15:0] frame_len_in = '0;
    logic        clr_cnt_in = 1'b0;
    logic        sample_valid_in = 1'b0;
    logic [31:0] sample_data_in = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tkeep;
    logic [4:0]  level;
    logic [15:0] ovf_cnt;
    logic [15:0] frame_cnt;

    zif_rx_framer #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .axis_clk        (clk),
        .rst_n           (rst_n),
        .enable_in       (enable_in),
        .frame_len_in    (frame_len_in),
        .clr_cnt_in      (clr_cnt_in),
        .sample_valid_in (sample_valid_in),
        .sample_data_in  (sample_data_in),
        .axis_tx_tvalid  (tvalid),
        .axis_tx_tready  (tready),
        .axis_tx_tdata   (tdata),
        .axis_tx_tlast   (tlast),
        .axis_tx_tkeep   (tkeep),
        .fifo_level_out  (level),
        .ovf_cnt_out     (ovf_cnt),
        .frame_cnt_out   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: expected output words {is_hdr, tlast, data}, in bus order.
    logic [33:0] exp_q[$];
    int m_level, m_len, m_cnt, m_frames, m_ovf, m_seq;
    bit m_active;
    int n_last, n_data;
    bit obs_valid;
    bit prev_v, prev_hs;
    logic [31:0] prev_d;

    task automatic model_reset();
        exp_q.delete();
        m_level = 0; m_len = 0; m_cnt = 0; m_frames = 0; m_ovf = 0; m_seq = 0;
        m_active = 0; prev_v = 0; prev_hs = 0; prev_d = '0;
    endtask

    // One clock of stimulus: observe previous state at negedge, drive inputs, advance the model.
    task automatic step(input bit v, input logic [31:0] d, input bit en, input int len,
                        input bit rdy, input bit clr);
        logic [33:0] f;
        bit hs, pop_data;
        int lvl0, idx;
        bit last;
        @(negedge clk);
        obs_valid = tvalid;
        n_cmp++;
        if (level !== 5'(m_level)) begin
            n_err++; $display("FAIL level: got %0d want %0d at %0t", level, m_level, $time);
        end
        n_cmp++;
        if (ovf_cnt !== 16'(m_ovf)) begin
            n_err++; $display("FAIL ovf_cnt: got %0d want %0d at %0t", ovf_cnt, m_ovf, $time);
        end
        n_cmp++;
        if (frame_cnt !== 16'(m_frames)) begin
            n_err++;
            $display("FAIL frame_cnt: got %0d want %0d at %0t", frame_cnt, m_frames, $time);
        end
`ifndef ZIF_FRAMER_HDR_EN
        n_cmp++;
        if (tvalid !== (m_level > 0)) begin
            n_err++; $display("FAIL tvalid: got %b want %b at %0t", tvalid, m_level > 0, $time);
        end
`endif
        if (prev_v && !prev_hs) begin
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== prev_d) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h at %0t",
                         tvalid, tdata, prev_d, $time);
            end
        end
        sample_valid_in = v; sample_data_in = d; enable_in = en;
        frame_len_in = 16'(len); tready = rdy; clr_cnt_in = clr;
        hs = tvalid && rdy;
        pop_data = 0;
        if (hs) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL word: got %h last=%b want none at %0t", tdata, tlast, $time);
            end else begin
                f = exp_q.pop_front();
                pop_data = !f[33];
                if (tdata !== f[31:0] || tlast !== f[32]) begin
                    n_err++;
                    $display("FAIL word: got %h last=%b want %h last=%b at %0t",
                             tdata, tlast, f[31:0], f[32], $time);
                end
                if (pop_data) n_data++;
                if (tlast === 1'b1) n_last++;
            end
        end
        prev_v = tvalid; prev_hs = hs; prev_d = tdata;
        lvl0 = m_level;
        if (pop_data) m_level--;
        if (v && (m_active || en)) begin
            if (lvl0 < DEPTH || pop_data) begin
                if (!m_active) begin
                    m_len = (len == 0) ? 1 : len;
                    idx = 1;
`ifdef ZIF_FRAMER_HDR_EN
                    exp_q.push_back({1'b1, 1'b0, 16'hA5A5, 16'(m_seq)});
                    m_seq = (m_seq + 1) % 65536;
`endif
                end else begin
                    idx = m_cnt + 1;
                end
                last = (idx == m_len);
                exp_q.push_back({1'b0, last, d});
                m_level++;
                if (last) begin
                    m_active = 0; m_frames = (m_frames + 1) % 65536;
                end else begin
                    m_active = 1; m_cnt = idx;
                end
            end else if (m_ovf < 65535) begin
                m_ovf++;
            end
        end
        if (clr) begin
            m_frames = 0; m_ovf = 0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 2000) begin
            step(0, 32'h0, 0, 1, 1, 0);
            k++;
        end
        step(0, 32'h0, 0, 1, 1, 0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tvalid !== 1'b0 || tdata !== 32'h0 || tlast !== 1'b0 || tkeep !== 4'hF) begin
            n_err++;
            $display("FAIL reset_out: got v=%b d=%h l=%b k=%h want 0/0/0/f",
                     tvalid, tdata, tlast, tkeep);
        end
        n_cmp++;
        if (level !== 5'd0 || ovf_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got lvl=%0d ovf=%0d fr=%0d want 0", level, ovf_cnt, frame_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_len4();
        n_last = 0;
        step(0, 32'h0, 1, 4, 1, 1);
        for (int i = 1; i <= 8; i++) begin
            step(1, 32'(i), 1, 4, 1, 0);
            if (i == 2) begin
                n_cmp++;
`ifdef ZIF_FRAMER_HDR_EN
                if (obs_valid !== 1'b0) begin
`else
                if (obs_valid !== 1'b1) begin
`endif
                    n_err++; $display("FAIL first_valid_latency: got %b", obs_valid);
                end
            end
        end
        drain();
        n_cmp++;
        if (frame_cnt !== 16'd2 || ovf_cnt !== 16'd0 || n_last != 2) begin
            n_err++;
            $display("FAIL basic_len4: got fr=%0d ovf=%0d lasts=%0d want 2/0/2",
                     frame_cnt, ovf_cnt, n_last);
        end
    endtask

    task automatic test_len0();
        n_last = 0;
        step(0, 32'h0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 32'hC0 + 32'(i), 1, 0, 1, 0);
        drain();
        n_cmp++;
        if (frame_cnt !== 16'd3 || n_last != 3) begin
            n_err++; $display("FAIL len0: got fr=%0d lasts=%0d want 3/3", frame_cnt, n_last);
        end
    endtask

    task automatic test_overflow();
        n_last = 0;
        step(0, 32'h0, 1, 8, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 32'h100 + 32'(i), 1, 8, 0, 0);
        step(0, 32'h0, 1, 8, 0, 0);
        n_cmp++;
        if (level !== 5'd16 || ovf_cnt !== 16'd4 || frame_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL overflow: got lvl=%0d ovf=%0d fr=%0d want 16/4/2",
                     level, ovf_cnt, frame_cnt);
        end
        // Dropped sample coinciding with clear: clear must win.
        step(1, 32'hDEAD, 1, 8, 0, 1);
        step(0, 32'h0, 1, 8, 0, 0);
        n_cmp++;
        if (ovf_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            n_err++; $display("FAIL clear_wins: got ovf=%0d fr=%0d want 0/0", ovf_cnt, frame_cnt);
        end
        drain();
        n_cmp++;
        if (n_last != 2 || frame_cnt !== 16'd0 || level !== 5'd0) begin
            n_err++;
            $display("FAIL overflow_drain: got lasts=%0d fr=%0d lvl=%0d want 2/0/0",
                     n_last, frame_cnt, level);
        end
    endtask

    task automatic test_enable_drop();
        n_last = 0; n_data = 0;
        step(0, 32'h0, 1, 5, 1, 1);
        for (int i = 1; i <= 9; i++) step(1, 32'h200 + 32'(i), (i <= 2), 5, 1, 0);
        drain();
        n_cmp++;
        if (frame_cnt !== 16'd1 || ovf_cnt !== 16'd0 || n_last != 1 || n_data != 5) begin
            n_err++;
            $display("FAIL enable_drop: got fr=%0d ovf=%0d lasts=%0d words=%0d want 1/0/1/5",
                     frame_cnt, ovf_cnt, n_last, n_data);
        end
    endtask

    task automatic test_random();
        int sent, cyc;
        sent = 0; cyc = 0; n_data = 0;
        step(0, 32'h0, 1, 7, 1, 1);
        while (sent < 1000 && cyc < 6000) begin
            bit v;
            v = ($urandom_range(0, 99) < 40);
            step(v, $urandom, 1, 7, $urandom_range(0, 1) == 1, 0);
            if (v) sent++;
            cyc++;
        end
        drain();
        n_cmp++;
        if (sent != 1000 || n_data + m_ovf < 990) begin
            n_err++;
            $display("FAIL random_volume: got sent=%0d words=%0d ovf=%0d want 1000 sent",
                     sent, n_data, m_ovf);
        end
    endtask

    task automatic test_midframe_reset();
        n_last = 0;
        step(0, 32'h0, 1, 10, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i), 1, 10, 0, 0);
        @(posedge clk);
        sample_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tvalid !== 1'b0 || level !== 5'd0 || ovf_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b lvl=%0d ovf=%0d want 0/0/0", tvalid, level, ovf_cnt);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(i), 1, 3, 1, 0);
        drain();
        n_cmp++;
        if (frame_cnt !== 16'd1 || n_last != 1) begin
            n_err++; $display("FAIL post_reset_frame: got fr=%0d lasts=%0d want 1/1", frame_cnt, n_last);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_len4();
        test_len0();
        test_overflow();
        test_enable_drop();
        test_random();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
